mmio_param_fifo: RTL and testbench

Parametrised circular-buffer FIFO that replaces the fixed shift-register FIFO behind the AFU's MMIO user register. The AFU pushes on MMIO writes to the data register and pops on MMIO reads, and status is exposed for a separate MMIO status register. The FIFO is generalised in width, depth and full-policy, and adds explicit push/pop handshakes, occupancy count, almost-full, sticky overflow/underflow flags and synchronous clear.

---
 rtl/mmio_param_fifo.sv | 104 ++++++++++
 tb/tb_mmio_param_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mmio_param_fifo.sv
// Parametrised circular-buffer FIFO behind the AFU MMIO data register.
// It has first-word-fall-through output, occupancy and almost-full status, and sticky error flags.
module mmio_param_fifo #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL     = DEPTH - 1,
    parameter bit          OVERWRITE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         d,
    input  logic                     pop,
    output logic [WIDTH-1:0]         q,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic is_empty, is_full;
    logic push_eff, pop_eff, rd_adv;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // An empty FIFO never bypasses, so a pop against it is ignored even alongside a push.
    assign pop_eff  = pop && !is_empty;
    assign push_eff = push && (!is_full || pop_eff || OVERWRITE);
    // Overwrite mode drops the oldest entry by advancing the read side on a full push.
    assign rd_adv   = pop_eff || (push && is_full && !pop && OVERWRITE);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_eff && !rd_adv) begin
            count_d = count_q + CW'(1);
        end else if (rd_adv && !push_eff) begin
            count_d = count_q - CW'(1);
        end
        if (push && is_full && !pop) begin
            overflow_d = 1'b1;
        end
        if (pop && is_empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; masking q on empty keeps the output defined.
    always_ff @(posedge clk) begin
        if (rst_n && !clr && push_eff) begin
            mem[wr_ptr_q] <= d;
        end
    end

    assign q           = is_empty ? '0 : mem[rd_ptr_q];
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count_q >= CW'(AFULL));
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_mmio_param_fifo.sv
// Directed bench for mmio_param_fifo, DEPTH=4, in drop (u0) and overwrite (u1) full-policies.
module tb_mmio_param_fifo;

    logic        clk = 1'b0;
    logic        rst_n, clr, push, pop;
    logic [63:0] d;

    logic [63:0] q0, q1;
    logic        empty0, full0, af0, ov0, un0;
    logic        empty1, full1, af1, ov1, un1;
    logic [2:0]  count0, count1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_param_fifo #(.WIDTH(64), .DEPTH(4), .OVERWRITE(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .d(d), .pop(pop),
        .q(q0), .empty(empty0), .full(full0), .almost_full(af0), .count(count0),
        .overflow(ov0), .underflow(un0)
    );

    mmio_param_fifo #(.WIDTH(64), .DEPTH(4), .OVERWRITE(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .d(d), .pop(pop),
        .q(q1), .empty(empty1), .full(full1), .almost_full(af1), .count(count1),
        .overflow(ov1), .underflow(un1)
    );

    task automatic step(input logic p, input logic [63:0] dv, input logic po, input logic c);
        push = p; d = dv; pop = po; clr = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; push = 1'b1; d = 64'h55; pop = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count0 !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count0); end
        n_checks++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b exp 1", empty0); end
        n_checks++; if (q0 !== 64'h0) begin n_fail++; $display("FAIL rst_q got %h exp 0", q0); end
        n_checks++; if ({ov0, un0, full0, af0} !== 4'b0) begin
            n_fail++; $display("FAIL rst_flags got %b exp 0000", {ov0, un0, full0, af0}); end
        rst_n = 1'b1; push = 1'b0;
        step(1'b1, 64'hA1, 1'b0, 1'b0);
        n_checks++; if (q0 !== 64'hA1 || empty0 !== 1'b0) begin
            n_fail++; $display("FAIL first_push q=%h empty=%b exp a1/0", q0, empty0); end
        step(1'b1, 64'hA2, 1'b0, 1'b0);
        n_checks++; if (af0 !== 1'b0) begin n_fail++; $display("FAIL afull_at2 got %b exp 0", af0); end
        step(1'b1, 64'hA3, 1'b0, 1'b0);
        n_checks++; if (count0 !== 3'd3) begin n_fail++; $display("FAIL a_count got %0d exp 3", count0); end
        n_checks++; if (af0 !== 1'b1 || full0 !== 1'b0) begin
            n_fail++; $display("FAIL a_flags af=%b full=%b exp 1/0", af0, full0); end
        n_checks++; if (q0 !== 64'hA1) begin n_fail++; $display("FAIL a_head got %h exp a1", q0); end
    endtask

    task automatic test_fill_drop;
        logic [63:0] exp_q [4] = '{64'hB1, 64'hB2, 64'hB3, 64'hB4};
        step(1'b0, 64'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 64'hB1 + 64'(i), 1'b0, 1'b0);
            n_checks++; if (full0 !== (i == 3)) begin
                n_fail++; $display("FAIL b_full%0d got %b exp %b", i, full0, (i == 3)); end
        end
        n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL b_ov_pre got %b exp 0", ov0); end
        step(1'b1, 64'hB5, 1'b0, 1'b0);
        n_checks++; if (ov0 !== 1'b1 || count0 !== 3'd4) begin
            n_fail++; $display("FAIL b_drop ov=%b count=%0d exp 1/4", ov0, count0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (q0 !== exp_q[i]) begin
                n_fail++; $display("FAIL b_pop%0d got %h exp %h", i, q0, exp_q[i]); end
            step(1'b0, 64'h0, 1'b1, 1'b0);
        end
        n_checks++; if (empty0 !== 1'b1 || q0 !== 64'h0 || un0 !== 1'b0) begin
            n_fail++; $display("FAIL b_drained empty=%b q=%h un=%b exp 1/0/0", empty0, q0, un0); end
    endtask

    task automatic test_overwrite;
        logic [63:0] exp_q [4] = '{64'hC3, 64'hC4, 64'hC5, 64'hC6};
        step(1'b0, 64'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 64'hC1 + 64'(i), 1'b0, 1'b0);
        n_checks++; if (count1 !== 3'd4 || ov1 !== 1'b1 || full1 !== 1'b1) begin
            n_fail++; $display("FAIL c_state count=%0d ov=%b full=%b exp 4/1/1", count1, ov1, full1); end
        n_checks++; if (q0 !== 64'hC1) begin n_fail++; $display("FAIL c_dropmode_head got %h exp c1", q0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (q1 !== exp_q[i]) begin
                n_fail++; $display("FAIL c_pop%0d got %h exp %h", i, q1, exp_q[i]); end
            step(1'b0, 64'h0, 1'b1, 1'b0);
        end
        n_checks++; if (empty1 !== 1'b1 || q1 !== 64'h0) begin
            n_fail++; $display("FAIL c_drained empty=%b q=%h exp 1/0", empty1, q1); end
    endtask

    task automatic test_simultaneous;
        logic [63:0] exp_q [4] = '{64'hD2, 64'hD3, 64'hD4, 64'hD9};
        step(1'b0, 64'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 64'hD1 + 64'(i), 1'b0, 1'b0);
        step(1'b1, 64'hD9, 1'b1, 1'b0);
        n_checks++; if (count0 !== 3'd4 || ov0 !== 1'b0 || q0 !== 64'hD2) begin
            n_fail++; $display("FAIL d_full_pp count=%0d ov=%b q=%h exp 4/0/d2", count0, ov0, q0); end
        n_checks++; if (count1 !== 3'd4 || ov1 !== 1'b0 || q1 !== 64'hD2) begin
            n_fail++; $display("FAIL d_full_pp_ow count=%0d ov=%b q=%h exp 4/0/d2", count1, ov1, q1); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (q0 !== exp_q[i]) begin
                n_fail++; $display("FAIL d_pop%0d got %h exp %h", i, q0, exp_q[i]); end
            step(1'b0, 64'h0, 1'b1, 1'b0);
        end
        step(1'b1, 64'hE1, 1'b1, 1'b0);
        n_checks++; if (count0 !== 3'd1 || q0 !== 64'hE1 || un0 !== 1'b1) begin
            n_fail++; $display("FAIL e_empty_pp count=%0d q=%h un=%b exp 1/e1/1", count0, q0, un0); end
    endtask

    task automatic test_wrap;
        logic [63:0] exp;
        step(1'b0, 64'h0, 1'b0, 1'b1);
        step(1'b1, 64'hF0, 1'b0, 1'b0);
        step(1'b1, 64'hF1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            exp = (k < 2) ? 64'hF0 + 64'(k) : 64'(k - 2);
            n_checks++; if (q0 !== exp) begin
                n_fail++; $display("FAIL w_head%0d got %h exp %h", k, q0, exp); end
            step(1'b1, 64'(k), 1'b1, 1'b0);
            n_checks++; if (count0 !== 3'd2) begin
                n_fail++; $display("FAIL w_count%0d got %0d exp 2", k, count0); end
        end
        for (int k = 8; k < 10; k++) begin
            n_checks++; if (q0 !== 64'(k)) begin
                n_fail++; $display("FAIL w_tail%0d got %h exp %h", k, q0, 64'(k)); end
            step(1'b0, 64'h0, 1'b1, 1'b0);
        end
        n_checks++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL w_empty got %b exp 1", empty0); end
    endtask

    task automatic test_flush;
        step(1'b0, 64'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 64'h10 + 64'(i), 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        n_checks++; if (count0 !== 3'd3 || ov0 !== 1'b1) begin
            n_fail++; $display("FAIL f_pre count=%0d ov=%b exp 3/1", count0, ov0); end
        step(1'b1, 64'h77, 1'b0, 1'b1);
        n_checks++; if (count0 !== 3'd0 || empty0 !== 1'b1 || q0 !== 64'h0) begin
            n_fail++; $display("FAIL f_clr count=%0d empty=%b q=%h exp 0/1/0", count0, empty0, q0); end
        n_checks++; if (ov0 !== 1'b0 || un0 !== 1'b0) begin
            n_fail++; $display("FAIL f_flags ov=%b un=%b exp 0/0", ov0, un0); end
        // A pop against an empty FIFO in the clr cycle must not leave underflow set.
        step(1'b0, 64'h0, 1'b1, 1'b1);
        n_checks++; if (un0 !== 1'b0 || empty0 !== 1'b1) begin
            n_fail++; $display("FAIL f_clr_underflow un=%b empty=%b exp 0/1", un0, empty0); end
    endtask

    initial begin
        test_reset();
        test_fill_drop();
        test_overwrite();
        test_simultaneous();
        test_wrap();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
